// File: rtl/seq_mag_comp_if.sv
// Start/busy/done handshake bundle for the sequential magnitude comparator.
// Master drives the request and operands; slave returns status and result.
interface seq_mag_comp_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator, MSB-first, DIGIT bits per clock.
// Signed compares flip both sign bits and then compare unsigned.
module seq_mag_comp #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic           clk,
  input logic           reset,
  seq_mag_comp_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] L_MSB =
    WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0] L_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_dec;
  logic             r_sgt;
  logic             r_slt;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_hi;
  logic             w_lo;
  logic             w_dec;
  logic             w_gt;
  logic             w_lt;
  logic             w_fin;
  logic [WIDTH-1:0] w_flip;

  // Operands shift left each cycle, so the live digit is always on top.
  assign w_da   = r_a[WIDTH-1 -: DIGIT];
  assign w_db   = r_b[WIDTH-1 -: DIGIT];
  assign w_hi   = w_da > w_db;
  assign w_lo   = w_da < w_db;
  assign w_dec  = r_dec | w_hi | w_lo;
  assign w_gt   = r_dec ? r_sgt : w_hi;
  assign w_lt   = r_dec ? r_slt : w_lo;
  assign w_fin  = (r_cnt == '0) ||
                  ((EARLY_EXIT != 0) && w_dec);
  assign w_flip = bus.signed_mode ? L_MSB : '0;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_sgt   <= 1'b0;
      r_slt   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_a     <= bus.a ^ w_flip;
            r_b     <= bus.b ^ w_flip;
            r_cnt   <= L_LAST;
            r_dec   <= 1'b0;
            r_sgt   <= 1'b0;
            r_slt   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_fin) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_gt    <= w_gt;
            r_lt    <= w_lt;
            r_eq    <= ~w_dec;
          end else begin
            r_dec <= w_dec;
            r_sgt <= w_gt;
            r_slt <= w_lt;
            r_cnt <= r_cnt - CW'(1);
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
